// File: rtl/vend_ctrl.sv
// vend_ctrl -- multi-product vending controller.
//
// Accepts coins, product selections, cancel requests and restock commands,
// tracks credit and per-item stock, and drives the dispenser and change
// hopper with single-cycle pulses. Every output is a register.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   coin_valid, coin_value     coin acceptor event and value
//   sel_valid, sel_item        keypad selection strobe and product index
//   cancel                     refund request
//   restock_valid/_item/_qty   add restock_qty units to restock_item
//   credit                     current credit
//   dispense_valid/_item       one-cycle dispense pulse and product
//   change_valid/_amount       one-cycle change pulse and value
//   coin_reject                one-cycle pulse, coin returned
//   err_funds, err_stock       one-cycle selection error pulses
//   stock_empty                bit i set when product i has no stock
//   busy                       controller is in VEND or CHANGE
module vend_ctrl #(
   parameter int N_ITEMS = 4,
   parameter int CW = 7,
   parameter logic [N_ITEMS*CW-1:0] PRICES = {7'd25, 7'd20, 7'd15, 7'd10},
   parameter int STOCK_W = 4,
   parameter int MAX_CREDIT = 100,
   localparam int SW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               coin_valid,
   input  logic [CW-1:0]      coin_value,
   input  logic               sel_valid,
   input  logic [SW-1:0]      sel_item,
   input  logic               cancel,
   input  logic               restock_valid,
   input  logic [SW-1:0]      restock_item,
   input  logic [STOCK_W-1:0] restock_qty,
   output logic [CW-1:0]      credit,
   output logic               dispense_valid,
   output logic [SW-1:0]      dispense_item,
   output logic               change_valid,
   output logic [CW-1:0]      change_amount,
   output logic               coin_reject,
   output logic               err_funds,
   output logic               err_stock,
   output logic [N_ITEMS-1:0] stock_empty,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

   localparam logic [STOCK_W-1:0] STOCK_MAX = {STOCK_W{1'b1}};

   state_t              state, state_n;
   logic [CW-1:0]       credit_n, change_n;
   logic [SW-1:0]       disp_item_n;
   logic                disp_n, chg_n, rej_n, efunds_n, estock_n, busy_n;
   logic                dec_en;
   logic [STOCK_W-1:0]  stock   [N_ITEMS];
   logic [STOCK_W-1:0]  stock_n [N_ITEMS];
   logic [N_ITEMS-1:0]  empty_n;

   logic                sel_hit;
   logic [STOCK_W-1:0]  sel_stock;
   logic [CW-1:0]       sel_price;
   logic [CW:0]         coin_sum;
   logic                coin_live;

   // stock + qty - dec, clamped to the counter maximum. dec is only set
   // when the stock is nonzero, so the subtraction cannot underflow.
   function automatic logic [STOCK_W-1:0] sat_stock(
      input logic [STOCK_W-1:0] s,
      input logic [STOCK_W-1:0] q,
      input logic               dec
   );
      logic [STOCK_W:0] t;
      t = {1'b0, s} + {1'b0, q} - (STOCK_W+1)'(dec);
      if (t > {1'b0, STOCK_MAX})
         return STOCK_MAX;
      return t[STOCK_W-1:0];
   endfunction

   // Table lookup by matching against every valid index, so an out-of-range
   // selection never indexes past the stock array or price table.
   always_comb begin
      sel_hit   = 1'b0;
      sel_stock = '0;
      sel_price = '0;
      for (int i = 0; i < N_ITEMS; i++) begin
         if (sel_item == SW'(i)) begin
            sel_hit   = 1'b1;
            sel_stock = stock[i];
            sel_price = PRICES[i*CW +: CW];
         end
      end
   end

   // One extra bit so a large coin cannot wrap around the ceiling check.
   assign coin_sum  = {1'b0, credit} + {1'b0, coin_value};
   assign coin_live = coin_valid && (coin_value != '0);

   always_comb begin
      state_n     = state;
      credit_n    = credit;
      change_n    = change_amount;
      disp_item_n = dispense_item;
      disp_n      = 1'b0;
      chg_n       = 1'b0;
      rej_n       = 1'b0;
      efunds_n    = 1'b0;
      estock_n    = 1'b0;
      dec_en      = 1'b0;
      case (state)
         IDLE, CREDIT: begin
            if (cancel) begin
               // A cancel owns the cycle even with zero credit.
               rej_n = coin_live;
               if (credit != '0) begin
                  change_n = credit;
                  credit_n = '0;
                  chg_n    = 1'b1;
                  state_n  = CHANGE;
               end
            end else if (sel_valid) begin
               rej_n = coin_live;
               if (!sel_hit || sel_stock == '0) begin
                  estock_n = 1'b1;
               end else if (credit < sel_price) begin
                  efunds_n = 1'b1;
               end else begin
                  credit_n    = credit - sel_price;
                  dec_en      = 1'b1;
                  disp_item_n = sel_item;
                  disp_n      = 1'b1;
                  state_n     = VEND;
               end
            end else if (coin_live) begin
               if (coin_sum <= (CW+1)'(MAX_CREDIT)) begin
                  credit_n = coin_sum[CW-1:0];
                  state_n  = CREDIT;
               end else begin
                  rej_n = 1'b1;
               end
            end
         end
         VEND: begin
            change_n = credit;
            credit_n = '0;
            chg_n    = (credit != '0);
            rej_n    = coin_live;
            state_n  = CHANGE;
         end
         CHANGE: begin
            rej_n   = coin_live;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n == VEND) || (state_n == CHANGE);
   end

   // Restock and dispense can hit the same item in one cycle; both are
   // folded into a single saturating update.
   always_comb begin
      for (int i = 0; i < N_ITEMS; i++) begin
         stock_n[i] = sat_stock(stock[i],
                                (restock_valid && restock_item == SW'(i)) ? restock_qty : '0,
                                dec_en && (sel_item == SW'(i)));
         empty_n[i] = (stock_n[i] == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         credit         <= '0;
         change_amount  <= '0;
         dispense_item  <= '0;
         dispense_valid <= 1'b0;
         change_valid   <= 1'b0;
         coin_reject    <= 1'b0;
         err_funds      <= 1'b0;
         err_stock      <= 1'b0;
         busy           <= 1'b0;
         stock_empty    <= '1;
         for (int i = 0; i < N_ITEMS; i++)
            stock[i] <= '0;
      end else begin
         state          <= state_n;
         credit         <= credit_n;
         change_amount  <= change_n;
         dispense_item  <= disp_item_n;
         dispense_valid <= disp_n;
         change_valid   <= chg_n;
         coin_reject    <= rej_n;
         err_funds      <= efunds_n;
         err_stock      <= estock_n;
         busy           <= busy_n;
         stock_empty    <= empty_n;
         for (int i = 0; i < N_ITEMS; i++)
            stock[i] <= stock_n[i];
      end
   end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl. Each step drives inputs, pushes the outputs
// expected after the next clock edge onto a queue, then pops and compares
// them one time unit after that edge. A second instance with three products
// shares all inputs and is checked only for the out-of-range selection.
module tb_vend_ctrl;

   logic       clk;
   logic       reset;
   logic       coin_valid;
   logic [6:0] coin_value;
   logic       sel_valid;
   logic [1:0] sel_item;
   logic       cancel;
   logic       restock_valid;
   logic [1:0] restock_item;
   logic [3:0] restock_qty;

   logic [6:0] credit;
   logic       dispense_valid;
   logic [1:0] dispense_item;
   logic       change_valid;
   logic [6:0] change_amount;
   logic       coin_reject;
   logic       err_funds;
   logic       err_stock;
   logic [3:0] stock_empty;
   logic       busy;

   logic [6:0] credit3;
   logic       dispense_valid3;
   logic [1:0] dispense_item3;
   logic       change_valid3;
   logic [6:0] change_amount3;
   logic       coin_reject3;
   logic       err_funds3;
   logic       err_stock3;
   logic [2:0] stock_empty3;
   logic       busy3;

   vend_ctrl dut (
      .clk(clk), .reset(reset),
      .coin_valid(coin_valid), .coin_value(coin_value),
      .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
      .restock_valid(restock_valid), .restock_item(restock_item), .restock_qty(restock_qty),
      .credit(credit), .dispense_valid(dispense_valid), .dispense_item(dispense_item),
      .change_valid(change_valid), .change_amount(change_amount),
      .coin_reject(coin_reject), .err_funds(err_funds), .err_stock(err_stock),
      .stock_empty(stock_empty), .busy(busy)
   );

   vend_ctrl #(.N_ITEMS(3), .PRICES({7'd20, 7'd15, 7'd10})) dut3 (
      .clk(clk), .reset(reset),
      .coin_valid(coin_valid), .coin_value(coin_value),
      .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
      .restock_valid(restock_valid), .restock_item(restock_item), .restock_qty(restock_qty),
      .credit(credit3), .dispense_valid(dispense_valid3), .dispense_item(dispense_item3),
      .change_valid(change_valid3), .change_amount(change_amount3),
      .coin_reject(coin_reject3), .err_funds(err_funds3), .err_stock(err_stock3),
      .stock_empty(stock_empty3), .busy(busy3)
   );

   typedef struct {
      string      tag;
      logic [6:0] credit;
      logic       dv;
      logic [1:0] di;
      logic       chk_di;
      logic       cv;
      logic [6:0] ca;
      logic       chk_ca;
      logic       cr;
      logic       ef;
      logic       es;
      logic [3:0] se;
      logic       busy;
      logic       chk3;
      logic       es3;
   } exp_t;

   exp_t e;
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input string name, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s/%s observed=%0d expected=%0d", tag, name, obs, expv);
      end
   endtask

   task automatic clear_inputs();
      coin_valid    = 1'b0;
      coin_value    = '0;
      sel_valid     = 1'b0;
      sel_item      = '0;
      cancel        = 1'b0;
      restock_valid = 1'b0;
      restock_item  = '0;
      restock_qty   = '0;
   endtask

   task automatic coin(input logic [6:0] v);
      coin_valid = 1'b1;
      coin_value = v;
   endtask

   task automatic sel(input logic [1:0] i);
      sel_valid = 1'b1;
      sel_item  = i;
   endtask

   task automatic restock(input logic [1:0] i, input logic [3:0] q);
      restock_valid = 1'b1;
      restock_item  = i;
      restock_qty   = q;
   endtask

   task automatic cyc(input string tag);
      exp_t x;
      e.tag = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      clear_inputs();
      x = sb.pop_front();
      chk(x.tag, "credit", 32'(credit), 32'(x.credit));
      chk(x.tag, "dispense_valid", 32'(dispense_valid), 32'(x.dv));
      if (x.chk_di) chk(x.tag, "dispense_item", 32'(dispense_item), 32'(x.di));
      chk(x.tag, "change_valid", 32'(change_valid), 32'(x.cv));
      if (x.chk_ca) chk(x.tag, "change_amount", 32'(change_amount), 32'(x.ca));
      chk(x.tag, "coin_reject", 32'(coin_reject), 32'(x.cr));
      chk(x.tag, "err_funds", 32'(err_funds), 32'(x.ef));
      chk(x.tag, "err_stock", 32'(err_stock), 32'(x.es));
      chk(x.tag, "stock_empty", 32'(stock_empty), 32'(x.se));
      chk(x.tag, "busy", 32'(busy), 32'(x.busy));
      if (x.chk3) chk(x.tag, "err_stock_n3", 32'(err_stock3), 32'(x.es3));
      e.dv = 0; e.chk_di = 0; e.cv = 0; e.chk_ca = 0;
      e.cr = 0; e.ef = 0; e.es = 0; e.chk3 = 0; e.es3 = 0;
   endtask

   initial begin
      clear_inputs();
      e = '{tag: "", credit: 0, dv: 0, di: 0, chk_di: 0, cv: 0, ca: 0, chk_ca: 0,
            cr: 0, ef: 0, es: 0, se: 4'b1111, busy: 0, chk3: 0, es3: 0};

      // Reset state
      reset = 1'b1;
      e.chk_di = 1; e.di = 0; e.chk_ca = 1; e.ca = 0;
      cyc("reset");
      cyc("reset_hold");
      reset = 1'b0;

      // Exact-price purchase, no change
      restock(0, 3);  e.se = 4'b1110;                   cyc("restock0");
      coin(5);        e.credit = 5;                     cyc("coin5a");
      coin(5);        e.credit = 10;                    cyc("coin5b");
      sel(0);         e.credit = 0; e.dv = 1; e.di = 0; e.chk_di = 1; e.busy = 1; cyc("sel0");
      e.busy = 1;                                       cyc("vend0_nochange");
      e.busy = 0;                                       cyc("idle0");

      // Purchase with change
      restock(1, 2);  e.se = 4'b1100;                   cyc("restock1");
      coin(10);       e.credit = 10;                    cyc("coin10a");
      coin(10);       e.credit = 20;                    cyc("coin10b");
      coin(5);        e.credit = 25;                    cyc("coin5c");
      sel(1);         e.credit = 10; e.dv = 1; e.di = 1; e.chk_di = 1; e.busy = 1; cyc("sel1");
      e.credit = 0; e.cv = 1; e.ca = 10; e.chk_ca = 1;  cyc("change10");
      e.busy = 0;                                       cyc("idle1");

      // Insufficient funds, stock priority, cancel
      restock(3, 1);  e.se = 4'b0100;                   cyc("restock3");
      coin(10);       e.credit = 10;                    cyc("coin10c");
      coin(5);        e.credit = 15;                    cyc("coin5d");
      sel(3);         e.ef = 1;                         cyc("err_funds3");
      sel(2);         e.es = 1;                         cyc("err_stock_prio");
      cancel = 1'b1;  e.credit = 0; e.cv = 1; e.ca = 15; e.chk_ca = 1; e.busy = 1; cyc("cancel15");
      e.busy = 0;                                       cyc("idle2");
      cancel = 1'b1;                                    cyc("cancel_zero");
      coin(0);                                          cyc("coin_zero");

      // Out-of-stock and out-of-range selection, credit ceiling
      coin(20);       e.credit = 20;                    cyc("coin20");
      sel(2);         e.es = 1;                         cyc("err_stock2");
      sel(3);         e.ef = 1; e.chk3 = 1; e.es3 = 1;  cyc("sel_idx3");
      coin(50);       e.credit = 70;                    cyc("coin50");
      coin(25);       e.credit = 95;                    cyc("coin25");
      coin(10);       e.cr = 1;                         cyc("reject105");
      coin(5);        e.credit = 100;                   cyc("accept100");
      coin(1);        e.cr = 1;                         cyc("reject101");
      coin(127);      e.cr = 1;                         cyc("reject_wide");
      cancel = 1'b1;  e.credit = 0; e.cv = 1; e.ca = 100; e.chk_ca = 1; e.busy = 1; cyc("cancel100");
      e.busy = 0;                                       cyc("idle3");

      // Coins while busy / with a selection, inputs ignored while busy
      coin(10);       e.credit = 10;                    cyc("coin10d");
      sel(0); coin(5); e.credit = 0; e.cr = 1; e.dv = 1; e.di = 0; e.chk_di = 1; e.busy = 1; cyc("sel_with_coin");
      coin(10);       e.cr = 1; e.busy = 1;             cyc("coin_in_vend");
      sel(0); cancel = 1'b1; e.busy = 0;                cyc("ignored_in_change");

      // Restock and dispense on the same item in one cycle
      coin(10);       e.credit = 10;                    cyc("coin10e");
      sel(0); restock(0, 15); e.credit = 0; e.dv = 1; e.di = 0; e.chk_di = 1; e.busy = 1; cyc("sel_restock0");
      e.busy = 1;                                       cyc("vend_rs");
      e.busy = 0;                                       cyc("idle4");

      // Saturating restock
      restock(3, 15);                                   cyc("sat3");
      restock(2, 14); e.se = 4'b0000;                   cyc("restock2_14");
      restock(2, 15);                                   cyc("sat2");

      // Cancel with a coin in the same cycle
      coin(10);       e.credit = 10;                    cyc("coin10f");
      cancel = 1'b1; coin(5); e.credit = 0; e.cr = 1; e.cv = 1; e.ca = 10; e.chk_ca = 1; e.busy = 1; cyc("cancel_coin");
      e.busy = 0;                                       cyc("idle5");

      // Reset during VEND discards the pending change
      coin(10);       e.credit = 10;                    cyc("coin10g");
      coin(10);       e.credit = 20;                    cyc("coin10h");
      sel(1);         e.credit = 5; e.dv = 1; e.di = 1; e.chk_di = 1; e.busy = 1; e.se = 4'b0010; cyc("sel1b");
      reset = 1'b1;   e.credit = 0; e.busy = 0; e.se = 4'b1111; e.chk_di = 1; e.di = 0; e.chk_ca = 1; e.ca = 0; cyc("reset_in_vend");
      reset = 1'b0;

      // Reset during CHANGE
      restock(0, 1);  e.se = 4'b1110;                   cyc("restock0b");
      coin(10);       e.credit = 10;                    cyc("coin10i");
      cancel = 1'b1;  e.credit = 0; e.cv = 1; e.ca = 10; e.chk_ca = 1; e.busy = 1; cyc("cancel10b");
      reset = 1'b1;   e.busy = 0; e.se = 4'b1111; e.chk_ca = 1; e.ca = 0; cyc("reset_in_change");
      reset = 1'b0;
      cyc("idle_final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
